// File: rtl/acc_cpu_pkg.sv
// Shared constants for the parametrised accumulator CPU.
// Holds the opcode field width, opcode values and FSM state encoding
// used by both the controller and the datapath top.
package acc_cpu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_LDA = 3'd0;
  localparam logic [OP_W-1:0] OP_STA = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_JMP = 3'd5;
  localparam logic [OP_W-1:0] OP_JZ  = 3'd6;
  localparam logic [OP_W-1:0] OP_HLT = 3'd7;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_RST     = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH   = 3'd1;
  localparam logic [ST_W-1:0] ST_DECODE  = 3'd2;
  localparam logic [ST_W-1:0] ST_EXEC_RD = 3'd3;
  localparam logic [ST_W-1:0] ST_EXEC_WR = 3'd4;
  localparam logic [ST_W-1:0] ST_HALT    = 3'd5;

endpackage

// File: rtl/acc_cpu_ctrl.sv
// Sequencing FSM for the accumulator CPU.
// Decodes bus strobes, address select and datapath load enables
// combinationally from the state register.
// Ports:
//   clk, reset      : clock, async active-low reset
//   opcode          : opcode field of the instruction register
//   zero            : accumulator == 0
//   mem_ready       : memory completes the current access this cycle
//   rd_mem, wr_mem  : bus strobes
//   addr_pc         : drive PC onto the address bus
//   addr_opnd       : drive IR operand address onto the address bus
//   ir_load, pc_inc : fetch completion enables
//   pc_jump         : load PC from operand address
//   ac_load         : update AC/carry from the ALU
//   halted          : FSM is in HALT
//
// state      | meaning
// -----------+---------------------------------------------
// ST_RST     | one idle cycle after reset release
// ST_FETCH   | read instruction at PC, wait for mem_ready
// ST_DECODE  | one cycle; branches resolve here
// ST_EXEC_RD | read operand, update AC/carry on mem_ready
// ST_EXEC_WR | write AC to operand address, wait mem_ready
// ST_HALT    | frozen until reset
module acc_cpu_ctrl
  import acc_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            rd_mem,
  output logic            wr_mem,
  output logic            addr_pc,
  output logic            addr_opnd,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_jump,
  output logic            ac_load,
  output logic            halted
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    addr_pc   = 1'b0;
    addr_opnd = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_jump   = 1'b0;
    ac_load   = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_RST: state_nxt = ST_FETCH;
      ST_FETCH: begin
        rd_mem  = 1'b1;
        addr_pc = 1'b1;
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND: state_nxt = ST_EXEC_RD;
          OP_STA: state_nxt = ST_EXEC_WR;
          OP_JMP: begin
            pc_jump   = 1'b1;
            state_nxt = ST_FETCH;
          end
          OP_JZ: begin
            pc_jump   = zero;
            state_nxt = ST_FETCH;
          end
          default: state_nxt = ST_HALT;
        endcase
      end
      ST_EXEC_RD: begin
        rd_mem    = 1'b1;
        addr_opnd = 1'b1;
        if (mem_ready) begin
          ac_load   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_EXEC_WR: begin
        wr_mem    = 1'b1;
        addr_opnd = 1'b1;
        if (mem_ready) state_nxt = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_RST;
    endcase
  end

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised multi-cycle accumulator CPU: datapath (PC, IR, AC, carry,
// ALU) plus the sequencing controller.
// Ports:
//   clk, reset    : clock, async active-low reset
//   data_bus_in   : memory read data, valid while mem_ready=1
//   mem_ready     : memory completes the current access this cycle
//   adr_bus       : memory address (0 when no access is active)
//   rd_mem/wr_mem : read/write strobes
//   data_bus_out  : write data (AC during a write, else 0)
//   halted        : CPU is in HALT
//   carry         : carry/borrow flag
//   zero          : AC == 0
module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADR_W    = 12,
  parameter logic [ADR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_bus_in,
  input  logic              mem_ready,
  output logic [ADR_W-1:0]  adr_bus,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] data_bus_out,
  output logic              halted,
  output logic              carry,
  output logic              zero
);

  logic [ADR_W-1:0]  pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic [OP_W-1:0]   opcode;
  logic [ADR_W-1:0]  opnd;
  logic              addr_pc, addr_opnd;
  logic              ir_load, pc_inc, pc_jump, ac_load;
  logic [DATA_W-1:0] alu_ac;
  logic              alu_c;

  assign opcode = ir[DATA_W-1 -: OP_W];
  assign opnd   = ir[ADR_W-1:0];
  assign zero   = (ac == '0);

  // Bits between the opcode and the operand address carry no meaning.
  if (DATA_W > ADR_W + OP_W) begin : g_spare
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[DATA_W-OP_W-1:ADR_W];
  end

  acc_cpu_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .addr_pc   (addr_pc),
    .addr_opnd (addr_opnd),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_jump   (pc_jump),
    .ac_load   (ac_load),
    .halted    (halted)
  );

  assign adr_bus      = addr_pc ? pc : (addr_opnd ? opnd : '0);
  assign data_bus_out = wr_mem ? ac : '0;

  always_comb begin
    alu_ac = ac;
    alu_c  = carry;
    case (opcode)
      OP_LDA: alu_ac = data_bus_in;
      OP_ADD: {alu_c, alu_ac} = {1'b0, ac} + {1'b0, data_bus_in};
      OP_SUB: begin
        alu_ac = ac - data_bus_in;
        alu_c  = (ac < data_bus_in);
      end
      OP_AND: alu_ac = ac & data_bus_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      ac    <= '0;
      carry <= 1'b0;
    end else begin
      if (ir_load) ir <= data_bus_in;
      // pc_inc (FETCH) and pc_jump (DECODE) are never active together.
      if (pc_inc)       pc <= pc + ADR_W'(1);
      else if (pc_jump) pc <= opnd;
      if (ac_load) begin
        ac    <= alu_ac;
        carry <= alu_c;
      end
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
module tb_acc_cpu_param;

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [15:0] d;
    logic        c;
    logic        z;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        mem_ready;
  logic [15:0] data_bus_in;
  logic [11:0] adr_bus;
  logic        rd_mem, wr_mem;
  logic [15:0] data_bus_out;
  logic        halted, carry, zero;

  logic [15:0] mem [4096];
  txn_t        log_q[$];
  txn_t        exp_q[$];

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int wcnt = 0;
  int wait_total = 0;
  int stable_viol = 0;
  int both_viol = 0;
  int halt_viol = 0;
  bit prev_pend = 0;
  logic        prev_rd, prev_wr;
  logic [11:0] prev_adr;
  logic [15:0] prev_dout;

  int          exp_cyc;
  logic        exp_c, exp_z;
  bit          exp_done;

  acc_cpu_param #(.DATA_W(16), .ADR_W(12), .RESET_PC(12'h000)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_bus_in  (data_bus_in),
    .mem_ready    (mem_ready),
    .adr_bus      (adr_bus),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .data_bus_out (data_bus_out),
    .halted       (halted),
    .carry        (carry),
    .zero         (zero)
  );

  assign data_bus_in = mem[adr_bus];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of the memory model: sample at the falling edge, choose
  // mem_ready for the coming rising edge, record completed accesses.
  task automatic step();
    bit   r;
    txn_t t;
    @(negedge clk);
    if (reset) begin
      if (prev_pend && (rd_mem !== prev_rd || wr_mem !== prev_wr || adr_bus !== prev_adr ||
                        data_bus_out !== prev_dout))
        stable_viol++;
      if (rd_mem && wr_mem) both_viol++;
      if (halted && (rd_mem || wr_mem)) halt_viol++;
      if (rd_mem || wr_mem) begin
        case (mode)
          0: r = 1'b1;
          1: r = ($urandom_range(0, 2) != 0);
          2: begin
            if (wcnt < 3) begin r = 1'b0; wcnt++; end
            else begin r = 1'b1; wcnt = 0; end
          end
          default: r = rd_mem;
        endcase
        mem_ready = r;
        if (!r) wait_total++;
        else begin
          t.wr = wr_mem;
          t.a  = adr_bus;
          t.d  = wr_mem ? data_bus_out : mem[adr_bus];
          t.c  = carry;
          t.z  = zero;
          log_q.push_back(t);
          if (wr_mem) mem[adr_bus] = data_bus_out;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      prev_pend = (rd_mem || wr_mem) && !mem_ready;
      prev_rd   = rd_mem;
      prev_wr   = wr_mem;
      prev_adr  = adr_bus;
      prev_dout = data_bus_out;
    end else begin
      prev_pend = 1'b0;
      wcnt      = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic reset_cpu();
    reset = 1'b0;
    repeat (3) step();
    log_q.delete();
    wait_total  = 0;
    stable_viol = 0;
    both_viol   = 0;
    halt_viol   = 0;
    reset = 1'b1;
  endtask

  task automatic run_until_halt(input int budget, output int cycles, output bit ok);
    cycles = 0;
    while (!halted && cycles < budget) begin
      step();
      cycles++;
    end
    ok = halted;
  endtask

  // Instruction-level interpreter: produces the expected bus transaction
  // list, final flags and zero-wait cycle count from the ISA rules.
  task automatic model_run();
    logic [15:0] mm [4096];
    logic [11:0] pc, a;
    logic [15:0] ac, w, m;
    logic [2:0]  op;
    logic        c;
    int          sum;
    int          steps;
    txn_t        t;
    mm = mem;
    exp_q.delete();
    pc = 12'h000; ac = 16'h0000; c = 1'b0;
    exp_cyc = 1; exp_done = 0; steps = 0;
    while (!exp_done && steps < 500) begin
      steps++;
      w = mm[pc];
      t.wr = 0; t.a = pc; t.d = w; t.c = c; t.z = (ac == 0);
      exp_q.push_back(t);
      pc = pc + 12'd1;
      op = w[15:13];
      a  = w[11:0];
      m  = mm[a];
      if (op <= 3'd4) begin
        exp_cyc += 3;
        t.wr = (op == 3'd1); t.a = a; t.d = (op == 3'd1) ? ac : m; t.c = c; t.z = (ac == 0);
        exp_q.push_back(t);
      end else begin
        exp_cyc += 2;
      end
      case (op)
        3'd0: ac = m;
        3'd1: mm[a] = ac;
        3'd2: begin
          sum = int'(ac) + int'(m);
          c   = (sum >= 65536);
          ac  = 16'(sum);
        end
        3'd3: begin
          c  = (ac < m);
          ac = ac - m;
        end
        3'd4: ac = ac & m;
        3'd5: pc = a;
        3'd6: if (ac == 0) pc = a;
        default: exp_done = 1;
      endcase
    end
    exp_c = c;
    exp_z = (ac == 0);
  endtask

  task automatic test_reset();
    clear_mem();
    mode  = 0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({rd_mem, wr_mem, halted, adr_bus, data_bus_out} !== 31'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got rd=%b wr=%b halted=%b adr=%h dout=%h want all 0",
                 i, rd_mem, wr_mem, halted, adr_bus, data_bus_out);
      end
    end
    checks++;
    if (carry !== 1'b0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags got carry=%b zero=%b want carry=0 zero=1", carry, zero);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rd_mem !== 1'b0 || wr_mem !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_cycle got rd=%b wr=%b want 0 0", rd_mem, wr_mem);
    end
    step();
    checks++;
    if (rd_mem !== 1'b1 || adr_bus !== 12'h000) begin
      failures++;
      $display("FAIL first_fetch got rd=%b adr=%h want rd=1 adr=000", rd_mem, adr_bus);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    int nwr;
    clear_mem();
    mem[0] = 16'h0010;
    mem[1] = 16'h4011;
    mem[2] = 16'h2012;
    mem[3] = 16'hE000;
    mem[12'h010] = 16'h0005;
    mem[12'h011] = 16'h0003;
    mode = 0;
    reset_cpu();
    run_until_halt(200, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_halt got halted=%b want 1 within 200 cycles", halted);
    end
    checks++;
    if (cyc != 12) begin
      failures++;
      $display("FAIL basic_latency got %0d cycles want 12", cyc);
    end
    nwr = 0;
    foreach (log_q[i]) if (log_q[i].wr) nwr++;
    checks++;
    if (log_q.size() != 7 || nwr != 1 || !log_q[5].wr || log_q[5].a !== 12'h012 || log_q[5].d !== 16'h0008) begin
      failures++;
      $display("FAIL basic_write got txns=%0d writes=%0d want 7 txns with one write of 0008 to 012",
               log_q.size(), nwr);
    end
    repeat (20) step();
    checks++;
    if (halt_viol != 0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL basic_halt_quiet got strobes_in_halt=%0d halted=%b want 0 and 1", halt_viol, halted);
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    bit ok;
    clear_mem();
    mem[0] = 16'h0051;
    mem[1] = 16'h2050;
    mem[2] = 16'hE000;
    mem[12'h051] = 16'hBEEF;
    mode = 2;
    reset_cpu();
    run_until_halt(300, cyc, ok);
    checks++;
    if (!ok || cyc != 24) begin
      failures++;
      $display("FAIL wait_latency got halted=%b cycles=%0d want 1 and 24", halted, cyc);
    end
    checks++;
    if (stable_viol != 0 || wait_total != 15) begin
      failures++;
      $display("FAIL wait_hold got unstable=%0d waits=%0d want 0 and 15", stable_viol, wait_total);
    end
    checks++;
    if (log_q.size() != 5 || log_q[0].a !== 12'h000 || log_q[2].a !== 12'h001 || log_q[4].a !== 12'h002 ||
        !log_q[3].wr || log_q[3].a !== 12'h050 || log_q[3].d !== 16'hBEEF || log_q[1].wr || log_q[4].wr) begin
      failures++;
      $display("FAIL wait_sequence got txns=%0d want fetch000 rd051 fetch001 wr050=BEEF fetch002", log_q.size());
    end
  endtask

  task automatic test_flags_branch();
    int cyc;
    bit ok;
    clear_mem();
    mem[0] = 16'h0100;
    mem[1] = 16'h6101;
    mem[2] = 16'hC020;
    mem[3] = 16'h21F0;
    mem[4] = 16'h0102;
    mem[5] = 16'h4103;
    mem[6] = 16'hC020;
    mem[7] = 16'hE000;
    mem[12'h020] = 16'hE000;
    mem[12'h100] = 16'h0005;
    mem[12'h101] = 16'h0007;
    mem[12'h102] = 16'hFFFF;
    mem[12'h103] = 16'h0001;
    mode = 1;
    reset_cpu();
    run_until_halt(400, cyc, ok);
    checks++;
    if (!ok || log_q.size() != 13) begin
      failures++;
      $display("FAIL flags_run got halted=%b txns=%0d want 1 and 13", halted, log_q.size());
    end else begin
      checks++;
      if (log_q[5].wr || log_q[5].a !== 12'h003) begin
        failures++;
        $display("FAIL jz_not_taken got fetch adr=%h want 003", log_q[5].a);
      end
      checks++;
      if (!log_q[6].wr || log_q[6].a !== 12'h1F0 || log_q[6].d !== 16'hFFFE || log_q[6].c !== 1'b1 ||
          log_q[6].z !== 1'b0) begin
        failures++;
        $display("FAIL sub_borrow got adr=%h data=%h carry=%b zero=%b want 1F0 FFFE 1 0",
                 log_q[6].a, log_q[6].d, log_q[6].c, log_q[6].z);
      end
      checks++;
      if (log_q[12].wr || log_q[12].a !== 12'h020) begin
        failures++;
        $display("FAIL jz_taken got last fetch adr=%h want 020", log_q[12].a);
      end
    end
    checks++;
    if (carry !== 1'b1 || zero !== 1'b1) begin
      failures++;
      $display("FAIL add_overflow got carry=%b zero=%b want 1 1", carry, zero);
    end
  endtask

  task automatic test_pc_wrap();
    int n;
    clear_mem();
    mem[0]       = 16'hAFFF;
    mem[12'hFFF] = 16'h0100;
    mem[12'h100] = 16'h1234;
    mode = 1;
    reset_cpu();
    n = 0;
    while (log_q.size() < 4 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (log_q.size() < 4) begin
      failures++;
      $display("FAIL wrap_timeout got txns=%0d want 4 within 200 cycles", log_q.size());
    end else begin
      checks++;
      if (log_q[0].a !== 12'h000 || log_q[1].a !== 12'hFFF || log_q[2].a !== 12'h100 ||
          log_q[2].d !== 16'h1234 || log_q[3].a !== 12'h000 || log_q[3].wr) begin
        failures++;
        $display("FAIL pc_wrap got adrs %h %h %h %h want 000 FFF 100 000",
                 log_q[0].a, log_q[1].a, log_q[2].a, log_q[3].a);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int  n;
    int  cyc;
    bit  ok;
    clear_mem();
    mem[0]       = 16'h0100;
    mem[1]       = 16'h2101;
    mem[12'h100] = 16'h00AA;
    mode = 3;
    reset_cpu();
    n = 0;
    while (!wr_mem && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!wr_mem) begin
      failures++;
      $display("FAIL midrst_reach_write got wr=%b want 1 within 50 cycles", wr_mem);
    end
    step();
    step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rd_mem, wr_mem, adr_bus, data_bus_out} !== 30'd0) begin
      failures++;
      $display("FAIL midrst_strobes got rd=%b wr=%b adr=%h dout=%h want all 0",
               rd_mem, wr_mem, adr_bus, data_bus_out);
    end
    checks++;
    if (zero !== 1'b1 || carry !== 1'b0) begin
      failures++;
      $display("FAIL midrst_regs got zero=%b carry=%b want 1 0", zero, carry);
    end
    checks++;
    if (log_q.size() != 3 || log_q[2].wr) begin
      failures++;
      $display("FAIL midrst_no_write got txns=%0d want 3 reads only", log_q.size());
    end
    mem[0]       = 16'h21F1;
    mem[1]       = 16'hE000;
    mem[12'h1F1] = 16'hFFFF;
    mode = 0;
    reset_cpu();
    run_until_halt(100, cyc, ok);
    checks++;
    if (!ok || log_q.size() != 3 || log_q[0].a !== 12'h000 || !log_q[1].wr || log_q[1].a !== 12'h1F1 ||
        log_q[1].d !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_restart got halted=%b txns=%0d want fetch 000 then write 0000 to 1F1",
               halted, log_q.size());
    end
  endtask

  task automatic test_random_programs();
    int          len;
    int          cyc;
    bit          ok;
    int          bad;
    logic [2:0]  op;
    logic [11:0] a;
    logic [15:0] vals [5];
    for (int it = 0; it < 25; it++) begin
      clear_mem();
      len = $urandom_range(4, 14);
      for (int i = 0; i < len - 2; i++) begin
        op = 3'($urandom_range(0, 6));
        if (op == 3'd5 || op == 3'd6) a = 12'($urandom_range(i + 1, len - 1));
        else a = 12'h100 + 12'($urandom_range(0, 7));
        mem[i] = {op, 1'($urandom_range(0, 1)), a};
      end
      mem[len - 2] = 16'h21FF;
      mem[len - 1] = 16'hE000;
      vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'hFFFF; vals[3] = 16'h8000;
      for (int i = 0; i < 8; i++) begin
        vals[4] = 16'($urandom);
        mem[12'h100 + i] = vals[$urandom_range(0, 4)];
      end
      model_run();
      mode = 1;
      reset_cpu();
      run_until_halt(3000, cyc, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_halt it=%0d got halted=%b want 1", it, halted);
      end
      bad = -1;
      if (log_q.size() == exp_q.size()) begin
        foreach (exp_q[i])
          if (bad < 0 && (log_q[i].wr != exp_q[i].wr || log_q[i].a !== exp_q[i].a ||
                          log_q[i].d !== exp_q[i].d || log_q[i].c !== exp_q[i].c || log_q[i].z !== exp_q[i].z))
            bad = i;
      end
      checks++;
      if (log_q.size() != exp_q.size() || bad >= 0) begin
        failures++;
        $display("FAIL rand_bus it=%0d got txns=%0d first_diff=%0d want txns=%0d",
                 it, log_q.size(), bad, exp_q.size());
      end
      checks++;
      if (carry !== exp_c || zero !== exp_z) begin
        failures++;
        $display("FAIL rand_flags it=%0d got carry=%b zero=%b want %b %b", it, carry, zero, exp_c, exp_z);
      end
      checks++;
      if (cyc != exp_cyc + wait_total) begin
        failures++;
        $display("FAIL rand_latency it=%0d got %0d cycles want %0d", it, cyc, exp_cyc + wait_total);
      end
      checks++;
      if (stable_viol != 0 || both_viol != 0) begin
        failures++;
        $display("FAIL rand_bus_rules it=%0d got unstable=%0d both_strobes=%0d want 0 0",
                 it, stable_viol, both_viol);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_basic();
    test_wait_states();
    test_flags_branch();
    test_pc_wrap();
    test_reset_mid_access();
    test_random_programs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
